stream_sorter: RTL
==================

Name: stream_sorter

Overview:
- Parametrised successor to the fixed 11-element sorter in the user project area.
- Loads up to pDEPTH elements of pELEM_WIDTH bits over AXI-Stream and sorts them with an odd-even transposition network, one phase per cycle.
- Streams the result back out over AXI-Stream.
- Control goes through AXI-Lite: ap_start/ap_done/ap_idle, a runtime length and an ascending/descending mode.

Parameters:
- pADDR_WIDTH, 12, AXI-Lite address width.
- pDATA_WIDTH, 32, AXI-Lite and AXI-Stream data width.
- pELEM_WIDTH, 16, sort key width; taken from ss_tdata[pELEM_WIDTH-1:0]. Must be <= pDATA_WIDTH.
- pDEPTH, 16, maximum element count. Must be even and >= 2.

Ports:
- axis_clk  in  1  clock.
- axis_rst  in  1  asynchronous active-high reset.
- awvalid/awready  in/out  1  AXI-Lite write address handshake.
- awaddr  in  pADDR_WIDTH  write address.
- wvalid/wready  in/out  1  write data handshake.
- wdata  in  pDATA_WIDTH  write data.
- arvalid/arready  in/out  1  read address handshake.
- araddr  in  pADDR_WIDTH  read address.
- rvalid/rready  out/in  1  read data handshake.
- rdata  out  pDATA_WIDTH  read data.
- ss_tvalid/ss_tready  in/out  1  input stream handshake.
- ss_tdata  in  pDATA_WIDTH  input element.
- ss_tlast  in  1  input last.
- sm_tvalid/sm_tready  out/in  1  output stream handshake.
- sm_tdata  out  pDATA_WIDTH  output element, zero-extended.
- sm_tlast  out  1  output last.

Behaviour:
- Reset values: ap_idle=1, ap_done=0, ap_start=0, length=pDEPTH, mode=0, state IDLE. All ready/valid outputs 0. rdata=0, sm_tdata=0, sm_tlast=0.
- Register map:
  - 0x00 ap_ctrl {..,idle[2],done[1],start[0]}.
  - 0x10 length [$clog2(pDEPTH):0].
  - 0x14 mode bit0: 0 = ascending, 1 = descending.
- AXI-Lite write: awready=wready=1 only in the cycle where awvalid&&wvalid; the write commits that cycle. Writes to 0x10/0x14 are ignored unless idle.
- AXI-Lite read: arready=1 when no read is pending. rdata is registered and rvalid is held until rready. A read of ap_ctrl clears ap_done in the cycle of the rvalid&&rready handshake.
- Length 0 → on start, go straight to DONE with ap_done=1 and no output. Length > pDEPTH is clamped to pDEPTH at start.
- State machine:
  - IDLE: start=1 → LOAD. Clears start and idle; latches len_eff and mode.
  - LOAD: ss_tready=1. Each accept writes slot cnt and increments cnt.
    - Exits to SORT when cnt == len_eff-1 is accepted, or on ss_tlast (len_eff := cnt+1).
    - On entry to SORT, unfilled slots are padded with all-ones (ascending) or zero (descending).
  - SORT: phase p = 0..pDEPTH-1, one per cycle.
    - Even p compares pairs (0,1),(2,3)…; odd p compares (1,2),(3,4)….
    - Compare-swap is unsigned, and the direction follows mode.
    - Exits after phase pDEPTH-1.
  - OUT: sm_tvalid=1, sm_tdata=slot[0]. On handshake, slots shift down by one.
    - sm_tlast=1 on element len_eff-1.
    - After the last handshake: ap_done=1, ap_idle=1, go to IDLE.
- Latency: the first output is valid pDEPTH+1 cycles after the last input accept.
- Backpressure: sm_tready low holds sm_tdata/sm_tlast stable. ss_tready is 0 outside LOAD.
- Ties keep equal values; output order among equal keys is unspecified.
- Start written while busy is ignored and not queued.
- Reset mid-operation returns to the reset state immediately; partial data is discarded.

Optional Feature:
- Macro: STREAM_SORTER_CYCLE_COUNT_EN.
- Defined: adds a read-only register 0x18 holding a 32-bit count of axis_clk cycles from start accept to the final output handshake.
  - Cleared on start, saturates at all-ones, readable at any time.
- Undefined: no counter hardware; reads of 0x18 return 0.

Decomposition:
- Package stream_sorter_pkg: register offsets (ADDR_AP_CTRL, ADDR_LENGTH, ADDR_MODE, ADDR_CYCLES), state enum (S_IDLE, S_LOAD, S_SORT, S_OUT), ap_ctrl bit indices.
- One sub-module, cmp_swap: parameter W; inputs a, b, desc; outputs lo, hi.
  - Combinational; pDEPTH/2 instances are generated.

Test Plan:
- Ascending, length=11: input 5,3,9,0,1023,7,7,2,8,1,4 → output 0,1,2,3,4,5,7,7,8,9,1023; tlast on the 11th; ap_ctrl reads 0x6 then 0x4.
- Descending, length=16: input 0..15 → output 15..0, first output pDEPTH+1 cycles after the last input.
- Early tlast: length=16, 4 inputs 40,10,30,20 with tlast on the 4th → exactly 4 outputs 10,20,30,40; no pad values appear.
- Backpressure: random sm_tready on the first case → identical sequence; data held stable while tvalid=1 and tready=0.
- Control edges:
  - Length 0 → done with no stream activity.
  - Length 20 → clamped to 16.
  - Mode write while busy → ignored.
  - Start while busy → ignored.
- Reset mid-SORT: assert axis_rst → all outputs at reset values, ap_ctrl=0x4. Next run sorts correctly.

Source files
------------

// File: rtl/stream_sorter_pkg.sv
// Shared definitions for the stream sorter: register offsets, FSM states and
// ap_ctrl bit positions.
package stream_sorter_pkg;

    localparam int ADDR_AP_CTRL = 'h00;
    localparam int ADDR_LENGTH  = 'h10;
    localparam int ADDR_MODE    = 'h14;
    localparam int ADDR_CYCLES  = 'h18;

    localparam int AP_START_BIT = 0;
    localparam int AP_DONE_BIT  = 1;
    localparam int AP_IDLE_BIT  = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SORT = 2'd2,
        S_OUT  = 2'd3
    } state_e;

endpackage

// File: rtl/stream_sorter_cmp.sv
// Compare-swap cell: lo receives the element that belongs at the lower index
// (smaller when ascending, larger when descending). Unsigned compare.
module cmp_swap #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         desc,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);
    logic swap;

    assign swap = desc ? (a < b) : (a > b);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/stream_sorter.sv
// AXI-Stream sorter: load up to pDEPTH keys, sort by odd-even transposition
// (one phase per cycle), stream them back out. Optional macro
// STREAM_SORTER_CYCLE_COUNT_EN adds a run-length cycle counter at 0x18.
module stream_sorter #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pELEM_WIDTH = 16,
    parameter int pDEPTH      = 16
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   ss_tvalid,
    output logic                   ss_tready,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast
);
    import stream_sorter_pkg::*;

    localparam int LW = $clog2(pDEPTH) + 1;
    localparam int PW = $clog2(pDEPTH);
    localparam int H  = pDEPTH / 2;
    localparam logic [LW-1:0] DEPTH_L = LW'(pDEPTH);

    state_e                 state_q, state_d;
    logic                   start_q, start_d, done_q, done_d, idle_q, idle_d;
    logic [LW-1:0]          len_q, len_d, len_eff_q, len_eff_d, cnt_q, cnt_d;
    logic                   mode_q, mode_d, desc_q, desc_d;
    logic [PW-1:0]          phase_q, phase_d;
    logic [pELEM_WIDTH-1:0] slot_q [pDEPTH];
    logic [pELEM_WIDTH-1:0] slot_d [pDEPTH];
    logic [pELEM_WIDTH-1:0] net_d  [pDEPTH];
    logic                   rvalid_q, rvalid_d, arready_q, arready_d, rd_ctrl_q, rd_ctrl_d;
    logic [pDATA_WIDTH-1:0] rdata_q, rdata_d, rd_mux;
    logic [31:0]            cyc_rd;
    logic [2:0]             ctrl;

    logic aw_hs, ar_hs, r_hs, acc, out_hs, load_last, out_last;
    logic unused_bits;

    assign unused_bits = ^{wdata, ss_tdata};

    assign aw_hs     = awvalid && wvalid;
    assign ar_hs     = arvalid && arready_q;
    assign r_hs      = rvalid_q && rready;
    assign acc       = ss_tvalid && ss_tready;
    assign out_hs    = sm_tvalid && sm_tready;
    assign load_last = ss_tlast || (cnt_q == len_eff_q - LW'(1));
    assign out_last  = (cnt_q == len_eff_q - LW'(1));

    assign awready = aw_hs;
    assign wready  = aw_hs;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;

    // Odd phases pair (2k+1, 2k+2); the last cell has no odd partner and idles.
    logic [pELEM_WIDTH-1:0] cmp_a [H];
    logic [pELEM_WIDTH-1:0] cmp_b [H];
    logic [pELEM_WIDTH-1:0] cmp_lo [H];
    logic [pELEM_WIDTH-1:0] cmp_hi [H];

    for (genvar k = 0; k < H; k++) begin : g_cmp
        if (k < H - 1) begin : g_mid
            assign cmp_a[k] = phase_q[0] ? slot_q[2*k+1] : slot_q[2*k];
            assign cmp_b[k] = phase_q[0] ? slot_q[2*k+2] : slot_q[2*k+1];
        end else begin : g_end
            assign cmp_a[k] = slot_q[2*k];
            assign cmp_b[k] = slot_q[2*k+1];
        end
        cmp_swap #(.W(pELEM_WIDTH)) u_cmp (
            .a    (cmp_a[k]),
            .b    (cmp_b[k]),
            .desc (desc_q),
            .lo   (cmp_lo[k]),
            .hi   (cmp_hi[k])
        );
    end

    always_comb begin
        net_d = slot_q;
        for (int k = 0; k < H; k++) begin
            if (!phase_q[0]) begin
                net_d[2*k]   = cmp_lo[k];
                net_d[2*k+1] = cmp_hi[k];
            end else if (k < H - 1) begin
                net_d[2*k+1]              = cmp_lo[k];
                net_d[(2*k+2) % pDEPTH]   = cmp_hi[k];
            end
        end
    end

`ifdef STREAM_SORTER_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (state_q == S_IDLE && start_q)
            cyc_d = '0;
        else if (state_q != S_IDLE && cyc_q != '1)
            cyc_d = cyc_q + 32'd1;
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) cyc_q <= '0;
        else          cyc_q <= cyc_d;
    end

    assign cyc_rd = cyc_q;
`else
    assign cyc_rd = '0;
`endif

    // FSM: state register
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_q && len_q != '0)            state_d = S_LOAD;
            S_LOAD:  if (acc && load_last)                  state_d = S_SORT;
            S_SORT:  if (phase_q == PW'(pDEPTH - 1))        state_d = S_OUT;
            S_OUT:   if (out_hs && out_last)                state_d = S_IDLE;
            default:                                        state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ss_tready = (state_q == S_LOAD);
        sm_tvalid = (state_q == S_OUT);
        sm_tlast  = sm_tvalid && out_last;
        sm_tdata  = sm_tvalid ? pDATA_WIDTH'(slot_q[0]) : '0;
    end

    always_comb begin
        ctrl               = '0;
        ctrl[AP_START_BIT] = start_q;
        ctrl[AP_DONE_BIT]  = done_q;
        ctrl[AP_IDLE_BIT]  = idle_q;
        rd_mux = '0;
        if (araddr == pADDR_WIDTH'(ADDR_AP_CTRL)) rd_mux = pDATA_WIDTH'(ctrl);
        if (araddr == pADDR_WIDTH'(ADDR_LENGTH))  rd_mux = pDATA_WIDTH'(len_q);
        if (araddr == pADDR_WIDTH'(ADDR_MODE))    rd_mux = pDATA_WIDTH'(mode_q);
        if (araddr == pADDR_WIDTH'(ADDR_CYCLES))  rd_mux = pDATA_WIDTH'(cyc_rd);
    end

    always_comb begin
        start_d   = start_q;
        done_d    = done_q;
        idle_d    = idle_q;
        len_d     = len_q;
        mode_d    = mode_q;
        len_eff_d = len_eff_q;
        desc_d    = desc_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        slot_d    = slot_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rd_ctrl_d = rd_ctrl_q;

        if (aw_hs && idle_q) begin
            if (awaddr == pADDR_WIDTH'(ADDR_AP_CTRL) && wdata[AP_START_BIT]) start_d = 1'b1;
            if (awaddr == pADDR_WIDTH'(ADDR_LENGTH)) len_d  = wdata[LW-1:0];
            if (awaddr == pADDR_WIDTH'(ADDR_MODE))   mode_d = wdata[0];
        end

        if (r_hs) begin
            rvalid_d = 1'b0;
            if (rd_ctrl_q) done_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d  = 1'b1;
            rdata_d   = rd_mux;
            rd_ctrl_d = (araddr == pADDR_WIDTH'(ADDR_AP_CTRL));
        end
        arready_d = !rvalid_d;

        case (state_q)
            S_IDLE: if (start_q) begin
                start_d = 1'b0;
                cnt_d   = '0;
                if (len_q == '0) begin
                    done_d = 1'b1;
                end else begin
                    idle_d    = 1'b0;
                    len_eff_d = (len_q > DEPTH_L) ? DEPTH_L : len_q;
                    desc_d    = mode_q;
                end
            end
            S_LOAD: if (acc) begin
                cnt_d = cnt_q + LW'(1);
                for (int i = 0; i < pDEPTH; i++) begin
                    if (LW'(i) == cnt_q) slot_d[i] = ss_tdata[pELEM_WIDTH-1:0];
                end
                if (load_last) begin
                    len_eff_d = cnt_q + LW'(1);
                    phase_d   = '0;
                    // Pads sort to the tail so they never reach the output.
                    for (int i = 0; i < pDEPTH; i++) begin
                        if (LW'(i) > cnt_q) slot_d[i] = {pELEM_WIDTH{~desc_q}};
                    end
                end
            end
            S_SORT: begin
                slot_d  = net_d;
                phase_d = phase_q + PW'(1);
                if (phase_q == PW'(pDEPTH - 1)) cnt_d = '0;
            end
            S_OUT: if (out_hs) begin
                for (int i = 0; i < pDEPTH - 1; i++) slot_d[i] = slot_q[i+1];
                cnt_d = cnt_q + LW'(1);
                if (out_last) begin
                    done_d = 1'b1;
                    idle_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            idle_q    <= 1'b1;
            len_q     <= DEPTH_L;
            mode_q    <= 1'b0;
            len_eff_q <= DEPTH_L;
            desc_q    <= 1'b0;
            cnt_q     <= '0;
            phase_q   <= '0;
            slot_q    <= '{default: '0};
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rd_ctrl_q <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            start_q   <= start_d;
            done_q    <= done_d;
            idle_q    <= idle_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            len_eff_q <= len_eff_d;
            desc_q    <= desc_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            slot_q    <= slot_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rd_ctrl_q <= rd_ctrl_d;
            arready_q <= arready_d;
        end
    end

endmodule
